obf_sub_sequencer: RTL and testbench

// - Walks the obfuscation substitution LUT on behalf of the decode stage. It accepts one

---
 rtl/obf_sub_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_obf_sub_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obf_sub_sequencer.sv
// Walks the obfuscation substitution LUT and emits sub/imm beats to decode over valid/ready.
// Optional watchdog: define OBF_SEQ_WDOG_EN to abort sequences that exceed MAX_STEPS words.
module obf_sub_sequencer #(
    parameter int IGU_W     = 7,
    parameter int PPC_W     = 5,
    parameter int LUT_W     = 16,
    parameter int MAX_STEPS = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_igu_valid,
    input  logic [IGU_W-1:0] i_igu_index,
    output logic             o_igu_ready,
    output logic [IGU_W-1:0] o_lut_index,
    output logic [PPC_W-1:0] o_lut_ppc,
    input  logic [LUT_W-1:0] i_lut_sub,
    input  logic [LUT_W-1:0] i_lut_imm,
    output logic             o_sub_valid,
    input  logic             i_sub_ready,
    output logic [LUT_W-1:0] o_sub_word,
    output logic [LUT_W-1:0] o_sub_imm,
    output logic             o_sub_has_imm,
    output logic             o_sub_end,
    output logic             o_sub_pass,
    output logic             o_obf_stall,
    output logic             o_seq_err
);

    // States: IDLE accept index / passthrough beat | RUN walk LUT | DRAIN hold END beat
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [LUT_W-1:0] END_WORD = '1;

    state_t           r_state;
    logic             r_igu_ready;
    logic             r_pass_pend;
    logic [IGU_W-1:0] r_lut_index;
    logic [PPC_W-1:0] r_lut_ppc;
    logic             r_valid;
    logic [LUT_W-1:0] r_word;
    logic [LUT_W-1:0] r_imm;
    logic             r_has_imm;
    logic             r_end;
    logic             r_pass;
    logic             r_stall;

    logic w_take;
    logic w_load;
    logic w_accept;
    logic w_is_end;
    logic w_has_imm;
    logic w_capture;
    logic w_wdog_hit;

    assign w_take    = r_valid & i_sub_ready;
    assign w_load    = ~r_valid | w_take;
    assign w_accept  = (r_state == S_IDLE) & r_igu_ready & i_igu_valid;
    assign w_is_end  = (i_lut_sub == END_WORD);
    assign w_has_imm = (i_lut_sub[LUT_W-1 -: 2] == 2'b01);
    assign w_capture = (r_state == S_RUN) & w_load & ~w_is_end;

`ifdef OBF_SEQ_WDOG_EN
    localparam int SW = $clog2(MAX_STEPS + 1);

    logic [SW-1:0] r_steps;
    logic          r_seq_err;

    assign w_wdog_hit = (r_steps == SW'(MAX_STEPS));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_steps   <= '0;
            r_seq_err <= 1'b0;
        end else begin
            r_seq_err <= w_capture & w_wdog_hit;
            if (w_accept)
                r_steps <= '0;
            else if (w_capture && !w_wdog_hit)
                r_steps <= r_steps + SW'(1);
        end
    end

    assign o_seq_err = r_seq_err;
`else
    logic w_unused_wdog;

    assign w_wdog_hit    = 1'b0;
    assign w_unused_wdog = (MAX_STEPS > 0);
    assign o_seq_err     = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_igu_ready <= 1'b1;
            r_pass_pend <= 1'b0;
            r_lut_index <= '0;
            r_lut_ppc   <= '0;
            r_valid     <= 1'b0;
            r_word      <= '0;
            r_imm       <= '0;
            r_has_imm   <= 1'b0;
            r_end       <= 1'b0;
            r_pass      <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_igu_ready <= 1'b0;
                        if (i_igu_index != '0) begin
                            r_lut_index <= i_igu_index;
                            r_lut_ppc   <= '0;
                            r_stall     <= 1'b1;
                            r_state     <= S_RUN;
                        end else begin
                            r_pass_pend <= 1'b1;
                        end
                    end else if (r_pass_pend) begin
                        // extra cycle keeps passthrough latency equal to a LUT walk
                        r_pass_pend <= 1'b0;
                        r_valid     <= 1'b1;
                        r_pass      <= 1'b1;
                        r_end       <= 1'b1;
                        r_has_imm   <= 1'b0;
                        r_word      <= '0;
                        r_imm       <= '0;
                    end else if (w_take) begin
                        r_valid     <= 1'b0;
                        r_pass      <= 1'b0;
                        r_end       <= 1'b0;
                        r_igu_ready <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (w_load) begin
                        r_valid <= 1'b1;
                        r_pass  <= 1'b0;
                        if (w_is_end || w_wdog_hit) begin
                            r_end     <= 1'b1;
                            r_has_imm <= 1'b0;
                            r_word    <= END_WORD;
                            r_imm     <= '0;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_end     <= 1'b0;
                            r_word    <= i_lut_sub;
                            r_has_imm <= w_has_imm;
                            r_imm     <= w_has_imm ? i_lut_imm : '0;
                            r_lut_ppc <= r_lut_ppc + (w_has_imm ? PPC_W'(2) : PPC_W'(1));
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_take) begin
                        r_valid     <= 1'b0;
                        r_end       <= 1'b0;
                        r_stall     <= 1'b0;
                        r_igu_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_igu_ready   = r_igu_ready;
    assign o_lut_index   = r_lut_index;
    assign o_lut_ppc     = r_lut_ppc;
    assign o_sub_valid   = r_valid;
    assign o_sub_word    = r_word;
    assign o_sub_imm     = r_imm;
    assign o_sub_has_imm = r_has_imm;
    assign o_sub_end     = r_end;
    assign o_sub_pass    = r_pass;
    assign o_obf_stall   = r_stall;

endmodule

// File: tb/tb_obf_sub_sequencer.sv
// Randomized bench for obf_sub_sequencer: a LUT array plus a sequence-walking reference model.
// Define OBF_SEQ_WDOG_EN to build the DUT with MAX_STEPS=4 and exercise the watchdog.
module tb_obf_sub_sequencer;

`ifdef OBF_SEQ_WDOG_EN
    localparam bit WDOG = 1'b1;
    localparam int MAXS = 4;
`else
    localparam bit WDOG = 1'b0;
    localparam int MAXS = 24;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_igu_valid;
    logic [6:0]  i_igu_index;
    logic        o_igu_ready;
    logic [6:0]  o_lut_index;
    logic [4:0]  o_lut_ppc;
    logic [15:0] i_lut_sub;
    logic [15:0] i_lut_imm;
    logic        o_sub_valid;
    logic        i_sub_ready;
    logic [15:0] o_sub_word;
    logic [15:0] o_sub_imm;
    logic        o_sub_has_imm;
    logic        o_sub_end;
    logic        o_sub_pass;
    logic        o_obf_stall;
    logic        o_seq_err;

    logic [15:0] lut_mem [0:127][0:31];
    logic [4:0]  w_ppc1;

    assign w_ppc1    = o_lut_ppc + 5'd1;
    assign i_lut_sub = lut_mem[o_lut_index][o_lut_ppc];
    assign i_lut_imm = lut_mem[o_lut_index][w_ppc1];

    always #5 clk = ~clk;

    obf_sub_sequencer #(
        .IGU_W(7), .PPC_W(5), .LUT_W(16), .MAX_STEPS(MAXS)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_igu_valid  (i_igu_valid),
        .i_igu_index  (i_igu_index),
        .o_igu_ready  (o_igu_ready),
        .o_lut_index  (o_lut_index),
        .o_lut_ppc    (o_lut_ppc),
        .i_lut_sub    (i_lut_sub),
        .i_lut_imm    (i_lut_imm),
        .o_sub_valid  (o_sub_valid),
        .i_sub_ready  (i_sub_ready),
        .o_sub_word   (o_sub_word),
        .o_sub_imm    (o_sub_imm),
        .o_sub_has_imm(o_sub_has_imm),
        .o_sub_end    (o_sub_end),
        .o_sub_pass   (o_sub_pass),
        .o_obf_stall  (o_obf_stall),
        .o_seq_err    (o_seq_err)
    );

    typedef struct {
        logic [15:0] word;
        logic [15:0] imm;
        bit          has_imm;
        bit          is_end;
        bit          pass;
        bit          err;
        logic [4:0]  ppc;
    } beat_t;

    beat_t q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    bit          m_busy, m_stall, m_first_pend, m_held;
    int          m_acc_cyc, m_err_seen, m_seq_beats;
    logic [15:0] h_word, h_imm;
    logic [2:0]  h_flags;
    logic [4:0]  h_ppc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] plain_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:14] == 2'b01) w[15] = 1'b1;
        if (w == 16'hFFFF) w[0] = 1'b0;
        return w;
    endfunction

    task automatic init_lut();
        logic [4:0] p;
        int n;
        for (int idx = 0; idx < 128; idx++) begin
            for (int a = 0; a < 32; a++) lut_mem[idx][a] = 16'($urandom);
            p = 5'd0;
            n = $urandom_range(0, WDOG ? 8 : 6);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    lut_mem[idx][p]        = {2'b01, 14'($urandom)};
                    lut_mem[idx][p + 5'd1] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                    p = p + 5'd2;
                end else begin
                    lut_mem[idx][p] = plain_word();
                    p = p + 5'd1;
                end
            end
            lut_mem[idx][p] = 16'hFFFF;
        end
        lut_mem[27][0] = 16'h0400;
        lut_mem[27][1] = 16'h4400;
        lut_mem[27][2] = 16'hFFFF;
        lut_mem[27][3] = 16'hFFFF;
        for (int a = 0; a < 4; a++) lut_mem[28][a] = 16'h0101 * 16'(a + 1);
        lut_mem[28][4] = 16'hFFFF;
        for (int a = 0; a < 5; a++) lut_mem[29][a] = 16'h1001 + 16'(a);
        lut_mem[29][5] = 16'hFFFF;
        if (WDOG) for (int a = 0; a < 32; a++) lut_mem[30][a] = 16'h2000;
    endtask

    // Expected beat list for one index: walk words, imm words are skipped, END or step limit stops
    task automatic build(input logic [6:0] idx);
        beat_t b;
        logic [4:0]  p;
        logic [15:0] w;
        int n;
        if (idx == 7'd0) begin
            b = '{word: 16'h0, imm: 16'h0, has_imm: 0, is_end: 1, pass: 1, err: 0, ppc: 5'd0};
            q.push_back(b);
            return;
        end
        p = 5'd0;
        n = 0;
        for (int guard = 0; guard < 64; guard++) begin
            w = lut_mem[idx][p];
            if (w == 16'hFFFF || (WDOG && n == MAXS)) begin
                b = '{word: 16'hFFFF, imm: 16'h0, has_imm: 0, is_end: 1, pass: 0,
                      err: (w != 16'hFFFF), ppc: p};
                q.push_back(b);
                return;
            end
            b.word    = w;
            b.has_imm = (w[15:14] == 2'b01);
            b.imm     = b.has_imm ? lut_mem[idx][p + 5'd1] : 16'h0;
            b.is_end  = 0;
            b.pass    = 0;
            b.err     = 0;
            b.ppc     = p;
            q.push_back(b);
            p = p + (b.has_imm ? 5'd2 : 5'd1);
            n++;
        end
        $display("FAIL model_walk: index %0d has no terminator", idx);
        n_err++;
    endtask

    task automatic cycle(input bit drv_valid, input logic [6:0] drv_idx, input bit drv_ready);
        beat_t e;
        bit    busy_now;
        @(negedge clk);
        cyc++;
        busy_now = m_busy;
        chk("igu_ready", {31'd0, o_igu_ready}, {31'd0, !busy_now});
        chk("obf_stall", {31'd0, o_obf_stall}, {31'd0, m_stall});
        if (o_seq_err) m_err_seen++;
        if (!WDOG) chk("seq_err_tied", {31'd0, o_seq_err}, 32'd0);
        if (m_first_pend && cyc == m_acc_cyc + 2) begin
            chk("first_beat_latency", {31'd0, o_sub_valid}, 32'd1);
            m_first_pend = 0;
        end
        if (m_held) begin
            chk("hold_valid", {31'd0, o_sub_valid}, 32'd1);
            chk("hold_word", {16'd0, o_sub_word}, {16'd0, h_word});
            chk("hold_imm", {16'd0, o_sub_imm}, {16'd0, h_imm});
            chk("hold_flags", {29'd0, o_sub_has_imm, o_sub_end, o_sub_pass}, {29'd0, h_flags});
            chk("hold_ppc", {27'd0, o_lut_ppc}, {27'd0, h_ppc});
        end
        if (o_sub_valid) chk("beat_expected", {31'd0, q.size() > 0}, 32'd1);

        i_igu_valid = drv_valid;
        i_igu_index = drv_idx;
        i_sub_ready = drv_ready;

        if (o_sub_valid && i_sub_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("beat_pass", {31'd0, o_sub_pass}, {31'd0, e.pass});
            chk("beat_end", {31'd0, o_sub_end}, {31'd0, e.is_end});
            if (!e.is_end) begin
                chk("beat_word", {16'd0, o_sub_word}, {16'd0, e.word});
                chk("beat_has_imm", {31'd0, o_sub_has_imm}, {31'd0, e.has_imm});
                chk("beat_imm", {16'd0, o_sub_imm}, {16'd0, e.imm});
                m_seq_beats++;
            end else begin
                chk("end_has_imm", {31'd0, o_sub_has_imm}, 32'd0);
                if (!e.pass) chk("end_ppc", {27'd0, o_lut_ppc}, {27'd0, e.ppc});
                chk("seq_err_count", m_err_seen, {31'd0, e.err});
                m_busy  = 0;
                m_stall = 0;
            end
        end
        if (!busy_now && drv_valid) begin
            build(drv_idx);
            m_busy       = 1;
            m_stall      = (drv_idx != 7'd0);
            m_acc_cyc    = cyc;
            m_first_pend = 1;
            m_err_seen   = 0;
            m_seq_beats  = 0;
        end
        m_held  = o_sub_valid && !i_sub_ready;
        h_word  = o_sub_word;
        h_imm   = o_sub_imm;
        h_flags = {o_sub_has_imm, o_sub_end, o_sub_pass};
        h_ppc   = o_lut_ppc;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && m_busy; i++) cycle(1'b0, 7'd0, 1'b1);
        if (m_busy) chk("drain_timeout", 32'd1, 32'd0);
        cycle(1'b0, 7'd0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        init_lut();
        m_busy = 0; m_stall = 0; m_first_pend = 0; m_held = 0;
        m_err_seen = 0; m_seq_beats = 0; m_acc_cyc = 0;
        i_rst_n     = 1'b0;
        i_igu_valid = 1'b1;
        i_igu_index = 7'd5;
        i_sub_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_igu_ready", {31'd0, o_igu_ready}, 32'd1);
        chk("rst_sub_valid", {31'd0, o_sub_valid}, 32'd0);
        chk("rst_obf_stall", {31'd0, o_obf_stall}, 32'd0);
        chk("rst_seq_err", {31'd0, o_seq_err}, 32'd0);
        chk("rst_lut_ppc", {27'd0, o_lut_ppc}, 32'd0);
        chk("rst_lut_index", {25'd0, o_lut_index}, 32'd0);
        i_igu_valid = 1'b0;
        i_rst_n     = 1'b1;

        cycle(1'b1, 7'd0, 1'b1);
        drain();

        cycle(1'b1, 7'd27, 1'b1);
        drain();

        cycle(1'b1, 7'd29, 1'b1);
        cycle(1'b0, 7'd0, 1'b1);
        cycle(1'b0, 7'd0, 1'b1);
        repeat (3) cycle(1'b0, 7'd0, 1'b0);
        drain();

        if (WDOG) begin
            cycle(1'b1, 7'd30, 1'b1);
            drain();
        end

        cycle(1'b1, 7'd28, 1'b1);
        for (int i = 0; i < 20 && m_seq_beats < 2; i++) cycle(1'b0, 7'd0, 1'b1);
        @(negedge clk);
        cyc++;
        i_rst_n = 1'b0;
        @(negedge clk);
        cyc++;
        chk("midrst_sub_valid", {31'd0, o_sub_valid}, 32'd0);
        chk("midrst_obf_stall", {31'd0, o_obf_stall}, 32'd0);
        chk("midrst_igu_ready", {31'd0, o_igu_ready}, 32'd1);
        i_rst_n = 1'b1;
        q.delete();
        m_busy = 0; m_stall = 0; m_first_pend = 0; m_held = 0;
        repeat (6) cycle(1'b0, 7'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] idx;
            idx = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            cycle($urandom_range(0, 2) != 0, idx, $urandom_range(0, 9) < 7);
        end
        drain();
        chk("queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
